pmem_banked_fetch: RTL and testbench

- Next-generation RV32IMC program memory, parametrised in depth.
- Two 16-bit banks (low/high halfword) support aligned and halfword-misaligned 32-bit fetches, with a registered one-cycle read.
- Fetch side uses a valid/ready request and a stallable response. Loader side is an AXI-style write with byte strobes.
- Sits between the core fetch stage and the interconnect write master.

---
 rtl/pmem_banked_fetch_if.sv | 45 ++++
 rtl/pmem_banked_fetch.sv | 133 +++++++++++++
 tb/tb_pmem_banked_fetch.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_banked_fetch_if.sv
// pmem_banked_fetch_if
//   Fetch and loader bus of the banked program memory.
//   master : core fetch stage / interconnect write master (drives requests)
//   slave  : the program memory
//   Fetch request : fetch_req_valid, fetch_req_ready, fetch_pc
//   Fetch response: fetch_rsp_valid, fetch_rsp_stall, fetch_instr, fetch_rsp_pc
//   Loader write  : wr_valid, wr_ready, wr_addr, wr_data, wr_strb
//   parity_err exists only when PMEM_PARITY_EN is defined.
interface pmem_banked_fetch_if #(
  parameter int PC_LEN = 32
);
  logic              fetch_req_valid;
  logic              fetch_req_ready;
  logic [PC_LEN-1:0] fetch_pc;
  logic              fetch_rsp_valid;
  logic              fetch_rsp_stall;
  logic [31:0]       fetch_instr;
  logic [PC_LEN-1:0] fetch_rsp_pc;
  logic              wr_valid;
  logic              wr_ready;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
`ifdef PMEM_PARITY_EN
  logic              parity_err;
`endif

  modport master (
    output fetch_req_valid, fetch_pc, fetch_rsp_stall,
    output wr_valid, wr_addr, wr_data, wr_strb,
    input  fetch_req_ready, fetch_rsp_valid, fetch_instr, fetch_rsp_pc, wr_ready
`ifdef PMEM_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  fetch_req_valid, fetch_pc, fetch_rsp_stall,
    input  wr_valid, wr_addr, wr_data, wr_strb,
    output fetch_req_ready, fetch_rsp_valid, fetch_instr, fetch_rsp_pc, wr_ready
`ifdef PMEM_PARITY_EN
    , output parity_err
`endif
  );
endinterface

// File: rtl/pmem_banked_fetch.sv
// pmem_banked_fetch
//   RV32IMC program memory built from two 16-bit banks (low / high halfword)
//   so that both aligned and halfword-misaligned 32-bit fetches complete in
//   one registered read cycle.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (clears the response, not memory)
//   bus  - pmem_banked_fetch_if.slave: fetch request/response + loader write
// Optional build macro:
//   PMEM_PARITY_EN - store an even-parity bit per halfword and flag
//                    bus.parity_err on a response built from a bad halfword.
module pmem_banked_fetch #(
  parameter int PC_LEN     = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input logic               clk,
  input logic               rst,
  pmem_banked_fetch_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [15:0] low_mem  [DEPTH];
  logic [15:0] high_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] low_rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  fetch_accept;

  logic              rsp_valid_reg;
  logic [PC_LEN-1:0] rsp_pc_reg;
  logic [15:0]       low_rd_reg;
  logic [15:0]       high_rd_reg;

  // PC bit 0, address bits above the word index and the byte offset of the
  // write address carry no meaning for this memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.fetch_pc[0], bus.fetch_pc[PC_LEN-1:DEPTH_LOG2+2],
                              bus.wr_addr[1:0], bus.wr_addr[31:DEPTH_LOG2+2]};

  assign rd_idx = bus.fetch_pc[DEPTH_LOG2+1:2];
  // A misaligned fetch takes its upper halfword from the next word's low
  // bank; the index width makes the last word wrap to word 0.
  assign low_rd_idx = bus.fetch_pc[1] ? rd_idx + DEPTH_LOG2'(1) : rd_idx;
  assign wr_idx     = bus.wr_addr[DEPTH_LOG2+1:2];

  // Writes always win, so a fetch never reads a word in the cycle it changes.
  assign bus.fetch_req_ready = !bus.wr_valid && (!rsp_valid_reg || !bus.fetch_rsp_stall);
  assign fetch_accept        = bus.fetch_req_valid && bus.fetch_req_ready;
  assign bus.wr_ready        = 1'b1;

`ifdef PMEM_PARITY_EN
  logic        low_par  [DEPTH];
  logic        high_par [DEPTH];
  logic [15:0] low_merged;
  logic [15:0] high_merged;
  logic        parity_err_reg;

  // Parity covers the halfword after the strobed merge, so the untouched
  // byte is read back and combined with the new one.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_merge
      assign low_merged[8*gi +: 8]  = bus.wr_strb[gi]
                                      ? bus.wr_data[8*gi +: 8]
                                      : low_mem[wr_idx][8*gi +: 8];
      assign high_merged[8*gi +: 8] = bus.wr_strb[gi+2]
                                      ? bus.wr_data[16+8*gi +: 8]
                                      : high_mem[wr_idx][8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst && bus.wr_valid) begin
      if (|bus.wr_strb[1:0]) begin
        low_mem[wr_idx] <= low_merged;
        low_par[wr_idx] <= ^low_merged;
      end
      if (|bus.wr_strb[3:2]) begin
        high_mem[wr_idx] <= high_merged;
        high_par[wr_idx] <= ^high_merged;
      end
    end
  end

  assign bus.parity_err = parity_err_reg;
`else
  always_ff @(posedge clk) begin
    if (!rst && bus.wr_valid) begin
      for (int b = 0; b < 2; b++) begin
        if (bus.wr_strb[b])
          low_mem[wr_idx][8*b +: 8] <= bus.wr_data[8*b +: 8];
        if (bus.wr_strb[b+2])
          high_mem[wr_idx][8*b +: 8] <= bus.wr_data[16+8*b +: 8];
      end
    end
  end
`endif

  // Response register doubles as the registered read port of both banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg  <= 1'b0;
      rsp_pc_reg     <= '0;
      low_rd_reg     <= '0;
      high_rd_reg    <= '0;
`ifdef PMEM_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else if (fetch_accept) begin
      rsp_valid_reg  <= 1'b1;
      rsp_pc_reg     <= bus.fetch_pc;
      low_rd_reg     <= low_mem[low_rd_idx];
      high_rd_reg    <= high_mem[rd_idx];
`ifdef PMEM_PARITY_EN
      parity_err_reg <= (^{low_par[low_rd_idx], low_mem[low_rd_idx]}) |
                        (^{high_par[rd_idx], high_mem[rd_idx]});
`endif
    end else if (!bus.fetch_rsp_stall) begin
      rsp_valid_reg  <= 1'b0;
`ifdef PMEM_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end
  end

  // The PC-order swap happens after the read register; the stored PC bit 1
  // tells which bank supplied the lower halfword.
  assign bus.fetch_rsp_valid = rsp_valid_reg;
  assign bus.fetch_rsp_pc    = rsp_pc_reg;
  assign bus.fetch_instr     = rsp_pc_reg[1] ? {low_rd_reg, high_rd_reg}
                                             : {high_rd_reg, low_rd_reg};
endmodule

// File: tb/tb_pmem_banked_fetch.sv
module tb_pmem_banked_fetch;
  localparam int PC_LEN     = 32;
  localparam int DEPTH_LOG2 = 9;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pmem_banked_fetch_if #(.PC_LEN(PC_LEN)) bus ();

  pmem_banked_fetch #(.PC_LEN(PC_LEN), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: halfword banks as plain arrays, response as three values.
  logic [15:0] m_lo [DEPTH];
  logic [15:0] m_hi [DEPTH];
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pc    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_fetch(input logic [31:0] pc);
    int idx = int'((pc >> 2) % DEPTH);
    int nxt = (idx + 1) % DEPTH;
    if (pc[1]) return {m_lo[nxt], m_hi[idx]};
    return {m_hi[idx], m_lo[idx]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'((a >> 2) % DEPTH);
    if (s[0]) m_lo[idx][7:0]  = d[7:0];
    if (s[1]) m_lo[idx][15:8] = d[15:8];
    if (s[2]) m_hi[idx][7:0]  = d[23:16];
    if (s[3]) m_hi[idx][15:8] = d[31:24];
  endtask

  // Compare process: decide from pre-edge inputs what the edge must do,
  // then check the DUT just after the edge.
  initial begin
    logic        exp_ready, take;
    logic        n_valid;
    logic [31:0] n_instr, n_pc;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        m_valid = 1'b0; m_instr = '0; m_pc = '0;
      end
      exp_ready = !bus.wr_valid && (!m_valid || !bus.fetch_rsp_stall);
      chk("req_ready", bus.fetch_req_ready, exp_ready);
      chk("wr_ready", bus.wr_ready, 1);
      take    = bus.fetch_req_valid && exp_ready && !rst;
      n_valid = m_valid; n_instr = m_instr; n_pc = m_pc;
      if (!rst) begin
        if (take) begin
          n_valid = 1'b1;
          n_instr = model_fetch(bus.fetch_pc);
          n_pc    = bus.fetch_pc;
        end else if (!bus.fetch_rsp_stall) begin
          n_valid = 1'b0;
        end
        if (bus.wr_valid) model_write(bus.wr_addr, bus.wr_data, bus.wr_strb);
      end
      @(posedge clk);
      #1;
      m_valid = n_valid; m_instr = n_instr; m_pc = n_pc;
      chk("rsp_valid", bus.fetch_rsp_valid, m_valid);
      if (m_valid) begin
        chk("rsp_instr", bus.fetch_instr, m_instr);
        chk("rsp_pc", bus.fetch_rsp_pc, m_pc);
      end
      if (rst) begin
        chk("rst_instr", bus.fetch_instr, 0);
        chk("rst_pc", bus.fetch_rsp_pc, 0);
      end
`ifdef PMEM_PARITY_EN
      chk("parity_err", bus.parity_err, 0);
`endif
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_strb = s;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic fetch_expect(input logic [31:0] pc, input logic [31:0] exp, input string nm);
    bit got = 0;
    @(negedge clk);
    bus.fetch_req_valid = 1'b1; bus.fetch_pc = pc;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (bus.fetch_req_ready) got = 1;
      @(negedge clk);
    end
    bus.fetch_req_valid = 1'b0;
    chk({nm, "_accept"}, 32'(got), 1);
    if (got) begin
      chk(nm, bus.fetch_instr, exp);
      chk({nm, "_pc"}, bus.fetch_rsp_pc, pc);
      chk({nm, "_valid"}, bus.fetch_rsp_valid, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.fetch_req_valid = 1'b0; bus.fetch_pc = '0; bus.fetch_rsp_stall = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid", bus.fetch_rsp_valid, 0);
    chk("reset_instr", bus.fetch_instr, 0);
    chk("reset_pc", bus.fetch_rsp_pc, 0);

    // Give every word a defined value so random fetches are predictable.
    for (int i = 0; i < DEPTH; i++) wr(32'(i * 4), $urandom, 4'hF);

    // Aligned and misaligned fetch.
    wr(32'h0, 32'h0013_0093, 4'hF);
    wr(32'h4, 32'h4502_8082, 4'hF);
    fetch_expect(32'h0, 32'h0013_0093, "aligned");
    fetch_expect(32'h2, 32'h8082_0013, "misaligned");

    // Last-word wrap of the low bank, PC wrap beyond depth, PC bit 0 ignored.
    wr(32'h7FC, 32'hAAAA_BBBB, 4'hF);
    wr(32'h0, 32'h1111_2222, 4'hF);
    fetch_expect(32'h7FE, 32'h2222_AAAA, "wrap_low");
    fetch_expect(32'h800, 32'h1111_2222, "pc_wrap");
    fetch_expect(32'h801, 32'h1111_2222, "pc_bit0");

    // Strobed partial write.
    wr(32'hC, 32'hFFFF_FFFF, 4'hF);
    wr(32'hC, 32'h0012_0000, 4'h4);
    fetch_expect(32'hC, 32'hFF12_FFFF, "strobe");
    wr(32'hC, 32'h5555_5555, 4'h0);
    fetch_expect(32'hC, 32'hFF12_FFFF, "strobe_none");

    // Write priority: three write cycles block the fetch, then it goes.
    @(negedge clk);
    bus.fetch_req_valid = 1'b1; bus.fetch_pc = 32'h14;
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = 32'h14; bus.wr_data = 32'h1000 + 32'(i); bus.wr_strb = 4'hF;
      #1;
      chk("wr_prio_ready", bus.fetch_req_ready, 0);
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    #1;
    chk("after_wr_ready", bus.fetch_req_ready, 1);
    @(negedge clk);
    bus.fetch_req_valid = 1'b0;
    chk("after_wr_valid", bus.fetch_rsp_valid, 1);
    chk("after_wr_instr", bus.fetch_instr, 32'h0000_1002);

    // Held response under stall ignores a later write to its word.
    wr(32'h18, 32'h1234_5678, 4'hF);
    fetch_expect(32'h18, 32'h1234_5678, "pre_stall");
    bus.fetch_rsp_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_valid = (i == 4);
      bus.wr_addr = 32'h18; bus.wr_data = 32'hCAFE_F00D; bus.wr_strb = 4'hF;
      @(negedge clk);
      chk("stall_instr", bus.fetch_instr, 32'h1234_5678);
      chk("stall_valid", bus.fetch_rsp_valid, 1);
    end
    bus.wr_valid = 1'b0; bus.fetch_rsp_stall = 1'b0;
    @(negedge clk);
    chk("rsp_clear", bus.fetch_rsp_valid, 0);
    fetch_expect(32'h18, 32'hCAFE_F00D, "post_stall");

    // Reset mid-response drops it; a write under reset does not land.
    wr(32'h1C, 32'h0BAD_BEEF, 4'hF);
    fetch_expect(32'h1C, 32'h0BAD_BEEF, "pre_rst");
    bus.fetch_rsp_stall = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_addr = 32'h1C; bus.wr_data = 32'hDEAD_DEAD; bus.wr_strb = 4'hF;
    #1;
    chk("midrst_valid", bus.fetch_rsp_valid, 0);
    chk("midrst_instr", bus.fetch_instr, 0);
    @(negedge clk);
    bus.wr_valid = 1'b0; bus.fetch_rsp_stall = 1'b0;
    rst = 1'b0;
    fetch_expect(32'h1C, 32'h0BAD_BEEF, "rst_no_write");

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.fetch_req_valid = ($urandom_range(0, 9) < 7);
      bus.fetch_pc        = 32'($urandom_range(0, 16'hFFFF));
      bus.fetch_rsp_stall = ($urandom_range(0, 9) < 3);
      bus.wr_valid        = ($urandom_range(0, 9) < 2);
      bus.wr_addr         = $urandom;
      bus.wr_data         = $urandom;
      bus.wr_strb         = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    bus.fetch_req_valid = 1'b0; bus.fetch_rsp_stall = 1'b0; bus.wr_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
